// File: rtl/alu_op_pkg.sv
// Mnemonic encodings and the mnemonic-to-ALU-opcode mapping shared by the
// opcode sequencer and anything that decodes its output.
package alu_op_pkg;

  typedef enum logic [1:0] {
    MN_ADD   = 2'd0,
    MN_SUB   = 2'd1,
    MN_ADDC  = 2'd2,
    MN_LOGIC = 2'd3
  } mnem_e;

  localparam logic [2:0] OPC_ADD   = 3'b000;
  localparam logic [2:0] OPC_SUB   = 3'b001;
  localparam logic [2:0] OPC_ADDC  = 3'b011;
  localparam logic [2:0] OPC_LOGIC = 3'b010;

  // Only 0xx codes are produced; 1xx is reserved on the ALU decoder.
  function automatic logic [2:0] mnem_to_opc(input logic [1:0] m);
    logic [2:0] opc;
    case (mnem_e'(m))
      MN_ADD:   opc = OPC_ADD;
      MN_SUB:   opc = OPC_SUB;
      MN_ADDC:  opc = OPC_ADDC;
      MN_LOGIC: opc = OPC_LOGIC;
      default:  opc = OPC_ADD;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous-reset FIFO with full/empty flags; DEPTH must be a power of two
// so the pointers wrap naturally.
module cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opcode_sequencer.sv
// Queues (mnemonic, repeat) commands and issues each as cmd_rep+1 registered
// ALU opcodes over a valid/ready handshake, with no bubble between commands.
module opcode_sequencer
  import alu_op_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [2:0]       Opcode,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             op_last,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  localparam int CW = REP_W + 2;

  state_e           state;
  logic [REP_W-1:0] remaining;
  logic [CW-1:0]    head;
  logic [1:0]       head_op;
  logic [REP_W-1:0] head_rep;
  logic             full, empty, push, pop;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head_op   = head[CW-1:REP_W];
  assign head_rep  = head[REP_W-1:0];
  assign busy      = (state != IDLE) || !empty;

  // Pop whenever the FSM will load the head this edge: from IDLE, or on the
  // final handshake of the current command.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE) pop = 1'b1;
      else if (op_ready && remaining == '0) pop = 1'b1;
    end
  end

  cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_op, cmd_rep}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Opcode    <= OPC_ADD;
      op_valid  <= 1'b0;
      op_last   <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            Opcode    <= mnem_to_opc(head_op);
            remaining <= head_rep;
            op_last   <= (head_rep == '0);
            op_valid  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_ready) begin
            if (remaining != '0) begin
              remaining <= remaining - 1'b1;
              op_last   <= (remaining == REP_W'(1));
            end else if (!empty) begin
              Opcode    <= mnem_to_opc(head_op);
              remaining <= head_rep;
              op_last   <= (head_rep == '0);
            end else begin
              op_valid  <= 1'b0;
              op_last   <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
